// File: rtl/vector_stream_tx.sv
// Transmit end of the flattened-vector interface: snapshots a whole vector on start
// and drains it one element per beat over a valid/ready stream in index order.
module vector_stream_tx #(
  parameter int unsigned ELEMENT_COUNT = 128,
  parameter int unsigned DATA_WIDTH    = 16,
  localparam int unsigned INDEX_WIDTH  = (ELEMENT_COUNT > 1) ? $clog2(ELEMENT_COUNT) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [DATA_WIDTH*ELEMENT_COUNT-1:0] data_in,
  output logic                                busy,
  output logic                                done,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DATA_WIDTH-1:0]               m_data,
  output logic [INDEX_WIDTH-1:0]              m_index,
  output logic                                m_last
);

  localparam int unsigned BUF_WIDTH = DATA_WIDTH * ELEMENT_COUNT;
  localparam logic [INDEX_WIDTH-1:0] INDEX_LAST = INDEX_WIDTH'(ELEMENT_COUNT - 1);

  if (ELEMENT_COUNT == 0) begin : g_bad_count
    $error("vector_stream_tx: ELEMENT_COUNT must be greater than zero");
  end

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [BUF_WIDTH-1:0]   buf_q, buf_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Buffer is a shift register: element k+1 always sits in the low slot when k is presented.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STREAM;
          buf_d   = data_in >> DATA_WIDTH;
          data_d  = data_in[DATA_WIDTH-1:0];
          index_d = '0;
          last_d  = (ELEMENT_COUNT == 1);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_STREAM: begin
        if (m_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + INDEX_WIDTH'(1);
            data_d  = buf_q[DATA_WIDTH-1:0];
            buf_d   = buf_q >> DATA_WIDTH;
            last_d  = (index_d == INDEX_LAST);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Snapshot storage carries no reset: its contents only matter after a start reloads it.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_index = index_q;
  assign m_last  = last_q;

endmodule

// File: tb/tb_vector_stream_tx.sv
// Bench for vector_stream_tx: directed cycle table, reset and single-element cases,
// then randomized traffic against a queue-based reference model.
module tb_vector_stream_tx;

  localparam int unsigned DW = 16;
  localparam int unsigned N4 = 4;
  localparam logic [63:0] VEC = 64'h8000_7FFF_FF80_0100;
  localparam logic [63:0] ALT = 64'hAAAA_AAAA_AAAA_AAAA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start4, ready4, busy4, done4, valid4, last4;
  logic [63:0] din4;
  logic [15:0] data4;
  logic [1:0]  idx4;

  logic        start1, ready1, busy1, done1, valid1, last1;
  logic [15:0] din1, data1;
  logic [0:0]  idx1;

  vector_stream_tx #(.ELEMENT_COUNT(N4), .DATA_WIDTH(DW)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .data_in(din4), .busy(busy4), .done(done4),
    .m_valid(valid4), .m_ready(ready4), .m_data(data4), .m_index(idx4), .m_last(last4)
  );

  vector_stream_tx #(.ELEMENT_COUNT(1), .DATA_WIDTH(DW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .data_in(din1), .busy(busy1), .done(done1),
    .m_valid(valid1), .m_ready(ready1), .m_data(data1), .m_index(idx1), .m_last(last1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check4(input string tag, input logic v, input logic [15:0] d, input int i,
                        input logic l, input logic b, input logic dn, input logic all_fields);
    chk({tag, ".m_valid"}, 32'(valid4), 32'(v));
    chk({tag, ".busy"},    32'(busy4),  32'(b));
    chk({tag, ".done"},    32'(done4),  32'(dn));
    chk({tag, ".m_last"},  32'(last4),  32'(l));
    if (v || all_fields) begin
      chk({tag, ".m_data"},  32'(data4), 32'(d));
      chk({tag, ".m_index"}, 32'(idx4),  32'(i));
    end
  endtask

  typedef struct {
    logic        s;
    logic        r;
    logic        alt;
    logic        v;
    logic [15:0] d;
    int          i;
    logic        l;
    logic        b;
    logic        dn;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic alt, input logic v,
                              input logic [15:0] d, input int i, input logic l,
                              input logic b, input logic dn);
    vec_t t;
    t.s = s; t.r = r; t.alt = alt; t.v = v; t.d = d; t.i = i; t.l = l; t.b = b; t.dn = dn;
    return t;
  endfunction

  typedef struct {
    logic [15:0] d;
    int          i;
  } beat_t;

  vec_t  tbl[15];
  beat_t q[$];
  logic  exp_done;
  logic  nd;
  beat_t bt;

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; ready4 = 1'b0; din4 = '0;
    start1 = 1'b0; ready1 = 1'b0; din1 = '0;

    // Each row: inputs held across one edge, then the outputs expected after it.
    tbl[0]  = mk(1, 1, 0, 1, 16'h0100, 0, 0, 1, 0);
    tbl[1]  = mk(0, 1, 1, 1, 16'hFF80, 1, 0, 1, 0);
    tbl[2]  = mk(1, 1, 1, 1, 16'h7FFF, 2, 0, 1, 0);
    tbl[3]  = mk(0, 1, 1, 1, 16'h8000, 3, 1, 1, 0);
    tbl[4]  = mk(1, 1, 1, 0, 16'h0000, 0, 0, 0, 1);
    tbl[5]  = mk(1, 1, 0, 1, 16'h0100, 0, 0, 1, 0);
    tbl[6]  = mk(0, 1, 1, 1, 16'hFF80, 1, 0, 1, 0);
    tbl[7]  = mk(0, 0, 1, 1, 16'hFF80, 1, 0, 1, 0);
    tbl[8]  = mk(0, 0, 1, 1, 16'hFF80, 1, 0, 1, 0);
    tbl[9]  = mk(0, 0, 1, 1, 16'hFF80, 1, 0, 1, 0);
    tbl[10] = mk(0, 1, 1, 1, 16'h7FFF, 2, 0, 1, 0);
    tbl[11] = mk(0, 1, 1, 1, 16'h8000, 3, 1, 1, 0);
    tbl[12] = mk(0, 1, 1, 0, 16'h0000, 0, 0, 0, 1);
    tbl[13] = mk(0, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    check4("reset", 0, 16'h0000, 0, 0, 0, 0, 1);
    chk("reset1.m_valid", 32'(valid1), 32'd0);
    chk("reset1.m_data",  32'(data1),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check4("idle", 0, 16'h0000, 0, 0, 0, 0, 1);

    for (int k = 0; k < 15; k++) begin
      start4 = tbl[k].s;
      ready4 = tbl[k].r;
      din4   = tbl[k].alt ? ALT : VEC;
      @(negedge clk);
      check4($sformatf("tbl%0d", k), tbl[k].v, tbl[k].d, tbl[k].i, tbl[k].l, tbl[k].b, tbl[k].dn, 0);
    end

    // Mid-stream reset while index 2 is pending.
    start4 = 1'b1; ready4 = 1'b1; din4 = VEC;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check4("pre_rst", 1, 16'h7FFF, 2, 0, 1, 0, 0);
    ready4 = 1'b0;
    #2 rst_n = 1'b0;
    #1 check4("async_rst", 0, 16'h0000, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    ready4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check4($sformatf("post_rst%0d", k), 0, 16'h0000, 0, 0, 0, 0, 0);
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check4("restart", 1, 16'h0100, 0, 0, 1, 0, 0);
    for (int k = 1; k < 4; k++) @(negedge clk);
    check4("restart_last", 1, 16'h8000, 3, 1, 1, 0, 0);
    @(negedge clk);
    check4("restart_done", 0, 16'h0000, 0, 0, 0, 1, 0);
    @(negedge clk);

    // Single-element vector.
    start1 = 1'b1; ready1 = 1'b0; din1 = 16'h1234;
    @(negedge clk);
    start1 = 1'b0; din1 = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ec1_beat%0d.m_valid", k), 32'(valid1), 32'd1);
      chk($sformatf("ec1_beat%0d.m_data", k),  32'(data1),  32'h1234);
      chk($sformatf("ec1_beat%0d.m_index", k), 32'(idx1),   32'd0);
      chk($sformatf("ec1_beat%0d.m_last", k),  32'(last1),  32'd1);
      chk($sformatf("ec1_beat%0d.busy", k),    32'(busy1),  32'd1);
      chk($sformatf("ec1_beat%0d.done", k),    32'(done1),  32'd0);
      @(negedge clk);
    end
    chk("ec1_held.m_data", 32'(data1), 32'h1234);
    ready1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("ec1_done.done",    32'(done1),  32'd1);
    chk("ec1_done.m_valid", 32'(valid1), 32'd0);
    chk("ec1_done.busy",    32'(busy1),  32'd0);
    chk("ec1_done.m_last",  32'(last1),  32'd0);
    @(negedge clk);
    chk("ec1_after.done",    32'(done1),  32'd0);
    chk("ec1_after.m_valid", 32'(valid1), 32'd0);

    // Randomized traffic against the queue model.
    rst_n = 1'b0; start4 = 1'b0; ready4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_done = 1'b0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      if (q.size() > 0)
        check4($sformatf("rnd%0d", c), 1, q[0].d, q[0].i, q[0].i == N4 - 1, 1, exp_done, 0);
      else
        check4($sformatf("rnd%0d", c), 0, 16'h0000, 0, 0, 0, exp_done, 0);
      start4 = ($urandom_range(0, 9) < 3);
      ready4 = ($urandom_range(0, 9) < 7);
      din4   = {$urandom(), $urandom()};
      nd = 1'b0;
      if (q.size() > 0) begin
        if (ready4) begin
          nd = (q[0].i == N4 - 1);
          void'(q.pop_front());
        end
      end else if (start4) begin
        for (int e = 0; e < N4; e++) begin
          bt.d = 16'(din4 >> (e * DW));
          bt.i = e;
          q.push_back(bt);
        end
      end
      exp_done = nd;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_stream_tx.md
# vector_stream_tx

Serializes a flattened fixed-point vector into a one-element-per-beat valid/ready stream. It is the transmit end of the flattened-vector interface used by the element-wise activation blocks. A full vector is snapshotted on a start pulse and then drained in index order under downstream back-pressure. It sits after vector-wide stages, such as the sigmoid output buffer, and feeds stream consumers: DMA, UART bridge and serial MAC lanes.

## Interface

- ELEMENT_COUNT, 128, number of elements per vector; must be > 0 (simulation-only $error otherwise).
- DATA_WIDTH, 16, bits per element (signed Q-format, passed through untouched).
- Derived INDEX_WIDTH = max(1, ceil(log2(ELEMENT_COUNT))).

- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request to send; honoured only while idle.
- data_in  input  DATA_WIDTH*ELEMENT_COUNT  flattened vector; element k = data_in[k*DATA_WIDTH +: DATA_WIDTH].
- busy  output  1  high from the cycle after an accepted start until the final beat is transferred.
- done  output  1  one-cycle pulse after the final beat.
- m_valid  output  1  stream element present.
- m_ready  input  1  downstream accepts; a transfer occurs on an edge where m_valid && m_ready.
- m_data  output  DATA_WIDTH  current element.
- m_index  output  INDEX_WIDTH  index of the current element.
- m_last  output  1  high with the element at index ELEMENT_COUNT-1.

## Operation

- States: IDLE and STREAM.
- **IDLE:**
  - m_valid=0, busy=0.
  - start=1 at an edge: copy all of data_in into the internal buffer, set m_index=0, load m_data with element 0, set m_valid=1 and busy=1, then go to STREAM.
- **STREAM:**
  - On a transfer of index k < ELEMENT_COUNT-1: m_index=k+1, m_data = buffer element k+1, m_last = (k+1 == ELEMENT_COUNT-1). m_valid stays 1.
  - On a transfer with m_last=1: m_valid, busy and m_last go to 0, done=1 for one cycle, return to IDLE.
- Snapshot semantics: data_in is don't-care after the accepting edge. Changes to it never alter the stream in progress.
- Stability rule: while m_valid=1 and m_ready=0, m_data, m_index and m_last hold.
- m_valid never drops without a transfer, except on reset.
- start while in STREAM (including the cycle of the final transfer) is ignored, not queued.
- start during the done cycle is accepted (state is IDLE), which gives back-to-back vectors.
- ELEMENT_COUNT=1: m_last=1 together with the first beat. The first transfer ends the vector.
- m_ready while m_valid=0 has no effect.
- Data is copied bit-exact: no rounding, saturation or sign change.

## Timing

- Reset (asynchronous assert, synchronous release by design convention): busy=0, done=0, m_valid=0, m_data=0, m_index=0, m_last=0, state=IDLE.
- Reset mid-stream aborts the vector immediately. No done pulse. The buffer contents are irrelevant afterwards.
- Start is sampled at edge E. Element 0 is valid in the cycle after E (1-cycle start latency).
- With m_ready held 1: element k transfers at edge E+1+k, and the final transfer is at edge E+ELEMENT_COUNT.
- done is high in the cycle after edge E+ELEMENT_COUNT, and busy is low in that same cycle.
- Throughput is one element per cycle with no bubbles between beats.
- Each m_ready=0 cycle during STREAM adds exactly one cycle of latency.
- done and m_valid are never high in the same cycle.

## Test plan

- ELEMENT_COUNT=4, data_in = {0x8000, 0x7FFF, 0xFF80, 0x0100} (element 0 = 0x0100), m_ready=1, start pulsed once:
  - beats 0x0100, 0xFF80, 0x7FFF, 0x8000 on four consecutive cycles with m_index 0..3;
  - m_last only on index 3;
  - done one cycle after the last beat; busy high for exactly 4 cycles.
- Back-pressure, same vector:
  - drop m_ready for 3 cycles while index 1 is presented: m_data=0xFF80 and m_index=1 hold for all 3 cycles, and no beat is skipped or repeated;
  - done is delayed by exactly 3 cycles.
- Snapshot: overwrite data_in with all 0xAAAA one cycle after start → the stream still carries the original four values.
- Start handling:
  - start asserted during STREAM and during the final-transfer cycle → ignored, and exactly one vector is sent;
  - start asserted in the done cycle → a second vector begins, with element 0 valid the next cycle.
- Reset: assert rst_n=0 while index 2 is pending → all outputs 0 immediately and no done pulse. The next start after release streams from index 0.
- ELEMENT_COUNT=1, data_in=0x1234 → a single beat with m_last=1 and m_index=0, then done the next cycle.
